// File: rtl/spi_slave_rx_buffer_if.sv
// rtl/spi_slave_rx_buffer_if.sv - push and FWFT pop stream signals of the SPI slave receive buffer
interface spi_slave_rx_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output in_data, in_valid, rx_ready,
    input  in_ready, rx_data, rx_valid
  );

  modport slave (
    input  in_data, in_valid, rx_ready,
    output in_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_rx_buffer.sv
// rtl/spi_slave_rx_buffer.sv - FWFT receive FIFO between the SPI CDC stage and the AXI plug write path
module spi_slave_rx_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  spi_slave_rx_buffer_if.slave     bus,
  input  logic                     flush,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   elements,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign elements    = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full = (elements >= PW'(AFULL_THRESH));

  assign bus.in_ready = !full;
  assign bus.rx_valid = !empty;
  assign bus.rx_data  = mem[rd_ptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a push into a full buffer is taken when popping.
  assign pop  = !empty && bus.rx_ready && !flush;
  assign push = bus.in_valid && (!full || pop) && !flush;
  assign drop = bus.in_valid && full && !pop && !flush;

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Set takes priority over clear so a drop in the clearing cycle is not lost.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: doc/spi_slave_rx_buffer.md
Name: spi_slave_rx_buffer

Overview:
- Single-clock receive buffer in the AXI clock domain, directly upstream of the SPI-slave AXI plug's write path.
- Accepts 32-bit words from the SPI-to-AXI clock-domain crossing, which cannot be back-pressured. Presents them to the plug on a first-word-fall-through valid/ready interface.
- Lets the SPI side keep shifting while the plug waits on AW/W/B handshakes.
- Reports fill level and almost-full. Records dropped words with a sticky overflow flag.

Parameters:
- DATA_WIDTH, 32, word width; must match plug rx_data.
- DEPTH, 8, number of entries; power of two, >= 2.
- AFULL_THRESH, 6, almost_full asserts when elements >= AFULL_THRESH; range 1..DEPTH.

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  reset, synchronous, active-high
- in_data  in  DATA_WIDTH  word from CDC stage
- in_valid  in  1  one-cycle push strobe; no back-pressure honoured
- in_ready  out  1  informational, = !full
- rx_data  out  DATA_WIDTH  head word to AXI plug
- rx_valid  out  1  head word valid (= !empty)
- rx_ready  in  1  plug pops head word
- flush  in  1  discard all contents (driven on cs rising / start of new write command)
- clr_overflow  in  1  clears sticky overflow
- elements  out  $clog2(DEPTH)+1  current fill level
- full  out  1  elements == DEPTH
- empty  out  1  elements == 0
- almost_full  out  1  elements >= AFULL_THRESH
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset: synchronous on axi_areset=1 at a rising edge of axi_aclk. Pointers = 0, elements = 0, overflow = 0, memory contents not reset. Resulting outputs: empty=1, full=0, almost_full=0, rx_valid=0, in_ready=1. rx_data is don't-care while rx_valid=0.
- Pointers: rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits with an extra wrap bit.
  - full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.
  - elements = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- push = in_valid & (!full | pop) & !flush. Writes mem[wr_ptr index] and increments wr_ptr; wraps naturally.
- pop = rx_valid & rx_ready & !flush. Increments rd_ptr.
- FWFT output: rx_data = mem[rd_ptr index] combinationally. A word pushed in cycle N is visible with rx_valid=1 in cycle N+1 (1-cycle latency).
- Simultaneous push and pop:
  - Allowed at any level, including full; elements is unchanged.
  - When full, the pop frees the slot in the same cycle, so the push is accepted with no overflow.
- Push while empty with rx_ready=1: no bypass. The word appears the next cycle.
- Overflow: in_valid & full & !pop & !flush sets overflow=1. The word is dropped; memory and pointers are unchanged.
- overflow stays set until clr_overflow=1. If set and clear occur in the same cycle, set wins.
- flush=1:
  - Next cycle: rd_ptr = wr_ptr = 0, elements = 0.
  - A push in the same cycle is discarded and does not set overflow; a pop in the same cycle is ignored.
  - overflow is not affected by flush.
- rx_ready while rx_valid=0: no effect.
- Status outputs (elements, full, empty, almost_full, in_ready) are combinational from registered pointers, with no input-to-output combinational paths. rx_valid depends only on registered state.
- Reset mid-operation: all stored words are lost and no pop is reported. The plug must tolerate rx_valid dropping.

Decomposition:
- No package needed; DATA_WIDTH, DEPTH and AFULL_THRESH stay module parameters.
- Pointer widths are derived by localparam inside the module.
- No sub-modules: a single module holding the register-array memory, pointer logic and status logic.

Test Plan:
- Reset then 3 pushes (0xA0000001, 0xA0000002, 0xA0000003), rx_ready=0 -> elements=3, rx_valid=1 from the cycle after the first push, rx_data=0xA0000001; then rx_ready=1 for 3 cycles -> words out in order, empty=1 after the third pop.
- Fill with 8 words (DEPTH=8) -> full=1, in_ready=0, almost_full=1 from elements=6. A 9th push with rx_ready=0 -> overflow=1, head still word 1, elements=8. clr_overflow -> overflow=0.
- Full buffer, push 0xBEEF0009 with rx_ready=1 in the same cycle -> overflow stays 0, elements stays 8; 0xBEEF0009 emerges 8th after the current head.
- Streaming 20 words with continuous push and pop (rx_ready=1) -> pointers wrap twice; output sequence identical to input; elements stays at 1 in steady state.
- 5 words stored, flush=1 with simultaneous in_valid (0xDEAD0000) -> next cycle elements=0, rx_valid=0, overflow=0; a subsequent push of 0x12345678 appears as the head.
- 4 words stored, axi_areset=1 for 1 cycle with in_valid=1 -> elements=0, rx_valid=0, overflow=0 after reset; the pushed word is not stored.
